// File: rtl/fb_write_buffer.sv
// Framebuffer store write buffer.
// Aligns M-stage framebuffer stores into word address, byte mask and lane data.
// Queues them in order and drains them to the shared framebuffer RAM port when granted.
module fb_write_buffer #(
    parameter int DEPTH     = 4,
    parameter int FB_WORDS  = 4096,
    parameter int FB_ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_fb_write,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_write_data,
    input  logic [1:0]           m_mem_size,
    output logic                 fb_stall,
    output logic                 fb_req,
    input  logic                 fb_grant,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [31:0]          fb_wdata,
    output logic [3:0]           fb_wmask,
    output logic                 fb_empty,
    output logic                 fb_err
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = FB_ADDR_W + 36;

    localparam logic [1:0]  SIZE_BYTE  = 2'd0;
    localparam logic [1:0]  SIZE_HALF  = 2'd1;
    localparam logic [29:0] FB_WORDS_W = 30'(FB_WORDS);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

    // FIFO state
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    // Entry storage: {word address, lane data, byte mask}
    logic [ENTRY_W-1:0] entry_mem [DEPTH];

    // Aligned view of the current store
    logic [1:0]  byte_off;
    logic [29:0] word_addr;
    logic [3:0]  new_mask;
    logic [31:0] new_wdata;
    logic        aligned;
    logic        in_range;
    logic        store_ok;
    logic [ENTRY_W-1:0] new_entry;

    // Handshake terms
    logic full;
    logic pop;
    logic push;
    logic [ENTRY_W-1:0] head_entry;

    // Align the store: byte enables, lane replication and legality
    always_comb begin
        byte_off  = m_addr[1:0];
        word_addr = m_addr[31:2];
        new_mask  = 4'b1111;
        new_wdata = m_write_data;
        aligned   = 1'b1;
        case (m_mem_size)
            SIZE_BYTE: begin
                new_mask  = 4'b0001 << byte_off;
                new_wdata = {4{m_write_data[7:0]}};
            end
            SIZE_HALF: begin
                aligned   = ~byte_off[0];
                new_mask  = 4'b0011 << byte_off;
                new_wdata = {2{m_write_data[15:0]}};
            end
            default: begin
                // WORD, and the reserved encoding treated as WORD
                aligned   = (byte_off == 2'b00);
                new_mask  = 4'b1111;
                new_wdata = m_write_data;
            end
        endcase
        in_range  = (word_addr < FB_WORDS_W);
        store_ok  = aligned && in_range;
        new_entry = {word_addr[FB_ADDR_W-1:0], new_wdata, new_mask};
    end

    // Push/pop decisions, stall, pointer and occupancy next-state
    always_comb begin
        full     = (count_q == COUNT_FULL);
        fb_req   = (count_q != '0);
        pop      = fb_req && fb_grant;
        // A full queue can still accept when the head leaves on the same edge
        push     = m_fb_write && store_ok && (!full || pop);
        // Rejected stores never stall; they only raise fb_err
        fb_stall = m_fb_write && store_ok && full && !fb_grant;

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        err_d = m_fb_write && !store_ok;
    end

    // Control registers with synchronous reset (reset discards queued entries)
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Entry storage write; contents need no reset because occupancy gates use
    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[wr_ptr_q] <= new_entry;
        end
    end

    // Head of queue drives the RAM port; mask is forced off when idle
    always_comb begin
        head_entry = entry_mem[rd_ptr_q];
        fb_addr    = head_entry[ENTRY_W-1 -: FB_ADDR_W];
        fb_wdata   = head_entry[35:4];
        fb_wmask   = fb_req ? head_entry[3:0] : 4'b0000;
        fb_empty   = (count_q == '0);
        fb_err     = err_q;
    end

endmodule

// File: tb/tb_fb_write_buffer.sv
// Self-checking bench for fb_write_buffer: scoreboard of expected RAM writes.
module tb_fb_write_buffer;

    localparam int DEPTH     = 4;
    localparam int FB_WORDS  = 4096;
    localparam int FB_ADDR_W = 12;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct {
        logic [FB_ADDR_W-1:0] addr;
        logic [31:0]          wdata;
        logic [3:0]           mask;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic                 m_fb_write;
    logic [31:0]          m_addr;
    logic [31:0]          m_write_data;
    logic [1:0]           m_mem_size;
    logic                 fb_stall;
    logic                 fb_req;
    logic                 fb_grant;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [31:0]          fb_wdata;
    logic [3:0]           fb_wmask;
    logic                 fb_empty;
    logic                 fb_err;

    int total = 0;
    int bad   = 0;

    // Model state
    exp_t sb[$];
    int   mcount   = 0;
    logic err_pend = 1'b0;
    logic cur_ok   = 1'b0;
    exp_t cur_exp;

    fb_write_buffer #(
        .DEPTH(DEPTH),
        .FB_WORDS(FB_WORDS),
        .FB_ADDR_W(FB_ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m_fb_write(m_fb_write),
        .m_addr(m_addr),
        .m_write_data(m_write_data),
        .m_mem_size(m_mem_size),
        .fb_stall(fb_stall),
        .fb_req(fb_req),
        .fb_grant(fb_grant),
        .fb_addr(fb_addr),
        .fb_wdata(fb_wdata),
        .fb_wmask(fb_wmask),
        .fb_empty(fb_empty),
        .fb_err(fb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference alignment: lane-by-lane enables and legality
    task automatic model(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data,
                         output logic ok, output exp_t e);
        logic [1:0] a;
        a       = addr[1:0];
        e.addr  = addr[13:2];
        e.mask  = 4'b0000;
        e.wdata = data;
        ok      = (addr[31:2] < 30'(FB_WORDS));
        if (sz == SZ_BYTE) begin
            e.mask[a] = 1'b1;
            e.wdata   = {data[7:0], data[7:0], data[7:0], data[7:0]};
        end else if (sz == SZ_HALF) begin
            if (a[0]) ok = 1'b0;
            e.mask[a]        = 1'b1;
            e.mask[a | 2'd1] = 1'b1;
            e.wdata          = {data[15:0], data[15:0]};
        end else begin
            if (a != 2'd0) ok = 1'b0;
            e.mask = 4'b1111;
        end
    endtask

    task automatic present(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
        logic ok;
        exp_t e;
        model(sz, addr, data, ok, e);
        m_mem_size   = sz;
        m_addr       = addr;
        m_write_data = data;
        m_fb_write   = 1'b1;
        cur_ok       = ok;
        cur_exp      = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a store and hold it until accepted (bounded)
    task automatic do_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
        int   n;
        logic st;
        n = 0;
        present(sz, addr, data);
        do begin
            @(negedge clk);
            #1;
            st = fb_stall;
            tick();
            n++;
        end while (st && n < 20);
        if (st) chk("store_timeout", 64'd1, 64'd0);
        m_fb_write = 1'b0;
    endtask

    // Cycle monitor: checks handshake outputs, pops scoreboard on writes, steps model
    logic exp_req, exp_stall, m_pop, m_push;
    exp_t got_e;
    always @(negedge clk) begin
        exp_req   = (mcount != 0);
        exp_stall = m_fb_write && cur_ok && (mcount == DEPTH) && !fb_grant;
        chk("req", 64'(fb_req), 64'(exp_req));
        chk("empty", 64'(fb_empty), 64'(!exp_req));
        chk("err", 64'(fb_err), 64'(err_pend));
        chk("stall", 64'(fb_stall), 64'(exp_stall));
        if (!exp_req) chk("mask_idle", 64'(fb_wmask), 64'd0);
        if (reset) begin
            sb.delete();
            mcount   = 0;
            err_pend = 1'b0;
        end else begin
            m_pop = exp_req && fb_grant;
            if (m_pop) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    got_e = sb.pop_front();
                    chk("wr_addr", 64'(fb_addr), 64'(got_e.addr));
                    chk("wr_data", 64'(fb_wdata), 64'(got_e.wdata));
                    chk("wr_mask", 64'(fb_wmask), 64'(got_e.mask));
                    $display("write addr=%h data=%h mask=%b", fb_addr, fb_wdata, fb_wmask);
                end
            end
            m_push = m_fb_write && cur_ok && ((mcount != DEPTH) || m_pop);
            if (m_push) sb.push_back(cur_exp);
            mcount   = mcount + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
            err_pend = m_fb_write && !cur_ok;
        end
    end

    task automatic drain();
        fb_grant = 1'b1;
        repeat (DEPTH + 2) tick();
        fb_grant = 1'b0;
    endtask

    logic        st_r;
    logic [1:0]  r_sz;
    logic [31:0] r_addr;
    int          r_sel;

    initial begin
        reset        = 1'b1;
        m_fb_write   = 1'b0;
        m_addr       = '0;
        m_write_data = '0;
        m_mem_size   = '0;
        fb_grant     = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_req", 64'(fb_req), 64'd0);
        chk("rst_empty", 64'(fb_empty), 64'd1);
        chk("rst_mask", 64'(fb_wmask), 64'd0);

        // T1: byte store lands on lane 1 of word 1
        do_store(SZ_BYTE, 32'h5, 32'h0000_00AB);
        chk("t1_req", 64'(fb_req), 64'd1);
        chk("t1_addr", 64'(fb_addr), 64'd1);
        chk("t1_mask", 64'(fb_wmask), 64'b0010);
        chk("t1_data", 64'(fb_wdata), 64'hABAB_ABAB);
        chk("t1_empty", 64'(fb_empty), 64'd0);

        // T2: upper half store, then misaligned half rejected
        do_store(SZ_HALF, 32'h6, 32'h0000_1234);
        do_store(SZ_HALF, 32'h3, 32'h0000_5678);
        chk("t2_err", 64'(fb_err), 64'd1);
        tick();
        chk("t2_err_clr", 64'(fb_err), 64'd0);
        drain();

        // T3: fill, stall, grant releases stall, drain in order 0..4
        do_store(SZ_WORD, 32'h0, 32'h1111_0000);
        do_store(SZ_WORD, 32'h4, 32'h1111_0001);
        do_store(SZ_WORD, 32'h8, 32'h1111_0002);
        do_store(SZ_WORD, 32'hC, 32'h1111_0003);
        present(SZ_WORD, 32'h10, 32'h1111_0004);
        @(negedge clk); #1;
        chk("t3_stall", 64'(fb_stall), 64'd1);
        tick();
        @(negedge clk); #1;
        chk("t3_stall_hold", 64'(fb_stall), 64'd1);
        tick();
        fb_grant = 1'b1;
        #1;
        chk("t3_stall_drop", 64'(fb_stall), 64'd0);
        tick();
        m_fb_write = 1'b0;
        drain();

        // T4: simultaneous push and pop with one entry queued
        do_store(SZ_BYTE, 32'h20, 32'h0000_0077);
        present(SZ_WORD, 32'h40, 32'hCAFE_F00D);
        fb_grant = 1'b1;
        tick();
        m_fb_write = 1'b0;
        fb_grant   = 1'b0;
        chk("t4_req", 64'(fb_req), 64'd1);
        chk("t4_addr", 64'(fb_addr), 64'h10);
        chk("t4_data", 64'(fb_wdata), 64'hCAFE_F00D);
        drain();

        // T5: reset discards queued entries
        do_store(SZ_WORD, 32'h100, 32'hA);
        do_store(SZ_WORD, 32'h104, 32'hB);
        do_store(SZ_WORD, 32'h108, 32'hC);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_req", 64'(fb_req), 64'd0);
        chk("t5_empty", 64'(fb_empty), 64'd1);
        chk("t5_mask", 64'(fb_wmask), 64'd0);
        fb_grant = 1'b1;
        repeat (4) tick();
        fb_grant = 1'b0;

        // T6: range boundary
        do_store(SZ_WORD, 32'h4000, 32'hDEAD_BEEF);
        chk("t6_err", 64'(fb_err), 64'd1);
        chk("t6_empty", 64'(fb_empty), 64'd1);
        do_store(SZ_WORD, 32'h3FFC, 32'h0BAD_CAFE);
        chk("t6_addr", 64'(fb_addr), 64'hFFF);
        drain();

        // Random traffic with random grant; stalled stores are re-presented
        st_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!st_r) begin
                if ($urandom_range(0, 3) != 0) begin
                    r_sz  = 2'($urandom_range(0, 3));
                    r_sel = $urandom_range(0, 9);
                    if (r_sel == 0)      r_addr = $urandom;
                    else if (r_sel == 1) r_addr = 32'h3FFC + $urandom_range(0, 8);
                    else                 r_addr = $urandom_range(0, 32'h3FFF);
                    present(r_sz, r_addr, $urandom);
                end else begin
                    m_fb_write = 1'b0;
                end
            end
            fb_grant = ($urandom_range(0, 2) == 0);
            @(negedge clk); #1;
            st_r = fb_stall;
            tick();
        end
        m_fb_write = 1'b0;
        drain();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("end_empty", 64'(fb_empty), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
